// File: rtl/fir_pkg.sv
// Shared types and arithmetic helpers for the fir_mac_engine FIR core.
// The GAIN state is only reached when FIR_GAIN_EN is defined.
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2,
        GAIN = 2'd3
    } fir_state_t;

    function automatic int acc_width(input int data_w, input int coef_w, input int ntaps);
        return data_w + coef_w + $clog2(ntaps);
    endfunction

    // Clamp a wide signed value into the range of a signed out_w-bit word.
    function automatic logic signed [63:0] saturate(input logic signed [63:0] value,
                                                    input int              out_w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (value > hi) begin
            return hi;
        end else if (value < lo) begin
            return lo;
        end else begin
            return value;
        end
    endfunction

endpackage

// File: rtl/fir_mac_engine_if.sv
// Sample, coefficient and result signals of fir_mac_engine.
// gain_i exists only when FIR_GAIN_EN is defined.
interface fir_mac_engine_if #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int NTAPS  = 8,
    parameter int OUT_W  = 16
);
    localparam int AW = $clog2(NTAPS);

    logic                     sample_valid_i;
    logic signed [DATA_W-1:0] sample_i;
    logic                     ready_o;
    logic                     coeff_we_i;
    logic [AW-1:0]            coeff_addr_i;
    logic signed [COEF_W-1:0] coeff_data_i;
    logic signed [OUT_W-1:0]  result_o;
    logic                     result_valid_o;
    logic                     busy_o;
`ifdef FIR_GAIN_EN
    logic [7:0]               gain_i;
`endif

    modport slave (
`ifdef FIR_GAIN_EN
        input  gain_i,
`endif
        input  sample_valid_i, sample_i, coeff_we_i, coeff_addr_i, coeff_data_i,
        output ready_o, result_o, result_valid_o, busy_o
    );

    modport master (
`ifdef FIR_GAIN_EN
        output gain_i,
`endif
        output sample_valid_i, sample_i, coeff_we_i, coeff_addr_i, coeff_data_i,
        input  ready_o, result_o, result_valid_o, busy_o
    );

endinterface

// File: rtl/fir_coeff_bank.sv
// NTAPS x COEF_W coefficient register file: synchronous write, asynchronous read.
// A write and a read of the same tap in one cycle returns the old value.
module fir_coeff_bank #(
    parameter  int NTAPS  = 8,
    parameter  int COEF_W = 16,
    localparam int AW     = $clog2(NTAPS)
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_en,
    input  logic                     i_we,
    input  logic [AW-1:0]            i_waddr,
    input  logic signed [COEF_W-1:0] i_wdata,
    input  logic [AW-1:0]            i_raddr,
    output logic signed [COEF_W-1:0] o_rdata
);

    logic signed [COEF_W-1:0] r_coef [NTAPS];
    logic                     w_addr_ok;

    // Addresses past the last tap exist when NTAPS is not a power of two.
    assign w_addr_ok = ({1'b0, i_waddr} < (AW + 1)'(NTAPS));

    // Coefficient storage with clear on reset and gated writes.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < NTAPS; i++) begin
                r_coef[i] <= '0;
            end
        end else if (i_en && i_we && w_addr_ok) begin
            r_coef[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_coef[i_raddr];

endmodule

// File: rtl/fir_mac_engine.sv
// Time-multiplexed FIR core: one multiply-accumulate per tap per cycle, then round/saturate.
// Define FIR_GAIN_EN to add the Q4.4 output gain stage (gain_i, extra GAIN cycle).
module fir_mac_engine #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int NTAPS  = 8,
    parameter int OUT_W  = 16,
    parameter int SHIFT  = 15
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clk_en_i,
    fir_mac_engine_if.slave bus
);
    import fir_pkg::*;

    localparam int AW    = $clog2(NTAPS);
    localparam int ACC_W = acc_width(DATA_W, COEF_W, NTAPS);
    localparam int P_W   = DATA_W + COEF_W;
    localparam logic signed [63:0] RND = (64'sd1 <<< SHIFT) >>> 1;

    fir_state_t               r_state;
    logic signed [DATA_W-1:0] r_win [NTAPS];
    logic signed [ACC_W-1:0]  r_acc;
    logic [AW-1:0]            r_k;
    logic signed [OUT_W-1:0]  r_result;
    logic                     r_result_valid;
    logic                     r_ready;
    logic                     r_busy;

    logic signed [COEF_W-1:0] w_coef;
    logic signed [P_W-1:0]    w_win_ext;
    logic signed [P_W-1:0]    w_coef_ext;
    logic signed [P_W-1:0]    w_prod;
    logic signed [ACC_W-1:0]  w_prod_ext;
    logic signed [63:0]       w_acc_ext;
    logic signed [63:0]       w_rnd;
    logic signed [63:0]       w_out_sat;

    fir_coeff_bank #(
        .NTAPS  (NTAPS),
        .COEF_W (COEF_W)
    ) u_coeff_bank (
        .i_clk   (clk_i),
        .i_rst   (rst_i),
        .i_en    (clk_en_i),
        .i_we    (bus.coeff_we_i),
        .i_waddr (bus.coeff_addr_i),
        .i_wdata (bus.coeff_data_i),
        .i_raddr (r_k),
        .o_rdata (w_coef)
    );

    // Operands are widened before multiplying so the product is exact.
    assign w_win_ext  = {{COEF_W{r_win[r_k][DATA_W-1]}}, r_win[r_k]};
    assign w_coef_ext = {{DATA_W{w_coef[COEF_W-1]}}, w_coef};
    assign w_prod     = w_win_ext * w_coef_ext;
    assign w_prod_ext = {{(ACC_W - P_W){w_prod[P_W-1]}}, w_prod};

    assign w_acc_ext  = {{(64 - ACC_W){r_acc[ACC_W-1]}}, r_acc};
    assign w_rnd      = (w_acc_ext + RND) >>> SHIFT;
    assign w_out_sat  = saturate(w_rnd, OUT_W);

`ifdef FIR_GAIN_EN
    logic signed [63:0] r_rnd;
    logic signed [63:0] w_gain_prod;
    logic signed [63:0] w_gain_sat;

    // gain_i is unsigned Q4.4, so the product drops four fraction bits.
    assign w_gain_prod = (r_rnd * $signed({56'd0, bus.gain_i})) >>> 4;
    assign w_gain_sat  = saturate(w_gain_prod, OUT_W);
`endif

    // Control FSM, sample window, accumulator and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            for (int i = 0; i < NTAPS; i++) begin
                r_win[i] <= '0;
            end
            r_acc          <= '0;
            r_k            <= '0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_ready        <= 1'b1;
            r_busy         <= 1'b0;
`ifdef FIR_GAIN_EN
            r_rnd          <= '0;
`endif
        end else if (clk_en_i) begin
            r_result_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.sample_valid_i) begin
                        for (int i = NTAPS - 1; i > 0; i--) begin
                            r_win[i] <= r_win[i-1];
                        end
                        r_win[0] <= bus.sample_i;
                        r_acc    <= '0;
                        r_k      <= '0;
                        r_state  <= MAC;
                        r_ready  <= 1'b0;
                        r_busy   <= 1'b1;
                    end
                end
                MAC: begin
                    r_acc <= r_acc + w_prod_ext;
                    if (r_k == AW'(NTAPS - 1)) begin
                        r_state <= OUT;
                    end else begin
                        r_k <= r_k + AW'(1);
                    end
                end
                OUT: begin
`ifdef FIR_GAIN_EN
                    r_rnd   <= w_rnd;
                    r_state <= GAIN;
`else
                    r_result       <= OUT_W'(w_out_sat);
                    r_result_valid <= 1'b1;
                    r_state        <= IDLE;
                    r_ready        <= 1'b1;
                    r_busy         <= 1'b0;
`endif
                end
`ifdef FIR_GAIN_EN
                GAIN: begin
                    r_result       <= OUT_W'(w_gain_sat);
                    r_result_valid <= 1'b1;
                    r_state        <= IDLE;
                    r_ready        <= 1'b1;
                    r_busy         <= 1'b0;
                end
`endif
                default: begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ready_o        = r_ready;
    assign bus.busy_o         = r_busy;
    assign bus.result_o       = r_result;
    assign bus.result_valid_o = r_result_valid;

endmodule

// File: tb/tb_fir_mac_engine.sv
// Self-checking bench for fir_mac_engine (NTAPS=4, SHIFT=0): transaction-level model
// compared every enabled cycle, plus directed vectors with hand-computed results.
module tb_fir_mac_engine;

    localparam int DW = 16;
    localparam int CW = 16;
    localparam int NT = 4;
    localparam int OW = 16;
    localparam int SH = 0;
`ifdef FIR_GAIN_EN
    localparam int LAT = NT + 2;
`else
    localparam int LAT = NT + 1;
`endif

    logic clk    = 1'b0;
    logic rst    = 1'b1;
    logic clk_en = 1'b1;

    always #5 clk = ~clk;

    fir_mac_engine_if #(.DATA_W(DW), .COEF_W(CW), .NTAPS(NT), .OUT_W(OW)) bus ();

    fir_mac_engine #(
        .DATA_W (DW),
        .COEF_W (CW),
        .NTAPS  (NT),
        .OUT_W  (OW),
        .SHIFT  (SH)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .clk_en_i (clk_en),
        .bus      (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    // ---------------- behavioural model ----------------
    longint m_win  [NT];
    longint m_coef [NT];
    longint m_sum      = 0;
    int     m_phase    = 0;
    bit     exp_ready  = 1'b1;
    bit     exp_busy   = 1'b0;
    bit     exp_valid  = 1'b0;
    longint exp_result = 0;

    function automatic longint sat_out(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic longint round_shift(input longint v);
        return (v + ((longint'(1) <<< SH) >>> 1)) >>> SH;
    endfunction

    // Phase p (1..NT) of a computation consumes tap p-1; phase LAT emits the result.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NT; i++) begin
                m_win[i]  <= 0;
                m_coef[i] <= 0;
            end
            m_phase    <= 0;
            m_sum      <= 0;
            exp_ready  <= 1'b1;
            exp_busy   <= 1'b0;
            exp_valid  <= 1'b0;
            exp_result <= 0;
        end else if (clk_en) begin
            exp_valid <= 1'b0;
            if (bus.coeff_we_i && int'(bus.coeff_addr_i) < NT)
                m_coef[bus.coeff_addr_i] <= longint'(bus.coeff_data_i);
            if (m_phase == 0) begin
                if (bus.sample_valid_i) begin
                    m_win[0] <= longint'(bus.sample_i);
                    for (int i = 1; i < NT; i++) m_win[i] <= m_win[i-1];
                    m_sum     <= 0;
                    m_phase   <= 1;
                    exp_ready <= 1'b0;
                    exp_busy  <= 1'b1;
                end
            end else if (m_phase <= NT) begin
                m_sum   <= m_sum + m_win[m_phase-1] * m_coef[m_phase-1];
                m_phase <= m_phase + 1;
            end else if (m_phase < LAT) begin
                m_phase <= m_phase + 1;
            end else begin
`ifdef FIR_GAIN_EN
                exp_result <= sat_out((round_shift(m_sum) * longint'(bus.gain_i)) >>> 4);
`else
                exp_result <= sat_out(round_shift(m_sum));
`endif
                exp_valid <= 1'b1;
                exp_ready <= 1'b1;
                exp_busy  <= 1'b0;
                m_phase   <= 0;
            end
        end
    end

    // Compare DUT against the model shortly after every active or reset edge.
    initial begin
        bit en_s;
        bit rs_s;
        forever begin
            @(posedge clk);
            en_s = clk_en;
            rs_s = rst;
            #2;
            if (rs_s || en_s) begin
                chk("cyc_ready", longint'(bus.ready_o), longint'(exp_ready));
                chk("cyc_busy", longint'(bus.busy_o), longint'(exp_busy));
                chk("cyc_valid", longint'(bus.result_valid_o), longint'(exp_valid));
                chk("cyc_result", longint'(bus.result_o), exp_result);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    int                 inj_at    = -1;
    longint             inj_val   = 0;
    int                 stall_at  = -1;
    int                 stall_len = 0;
    int                 wr_at     = -1;
    logic [$clog2(NT)-1:0] wr_addr = '0;
    longint             wr_data   = 0;
    int                 rst_at    = -1;

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wr_coef(input int addr, input longint data);
        bus.coeff_we_i   = 1'b1;
        bus.coeff_addr_i = addr[$clog2(NT)-1:0];
        bus.coeff_data_i = data[CW-1:0];
        @(negedge clk);
        bus.coeff_we_i   = 1'b0;
    endtask

    task automatic set_coeffs(input longint c0, input longint c1, input longint c2, input longint c3);
        wr_coef(0, c0);
        wr_coef(1, c1);
        wr_coef(2, c2);
        wr_coef(3, c3);
    endtask

    // Offer one sample, then track posedges after acceptance (n) until the result pulse.
    task automatic run_sample(input longint s, input bit expect_none,
                              output longint res, output int lat);
        int guard  = 0;
        int n      = 0;
        int nvalid = 0;
        int limit;
        res   = 0;
        lat   = -1;
        limit = expect_none ? 15 : 60;
        while (!bus.ready_o && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.ready_o) begin
            chk("ready_wait", longint'(bus.ready_o), 1);
            return;
        end
        bus.sample_valid_i = 1'b1;
        bus.sample_i       = s[DW-1:0];
        @(posedge clk);
        @(negedge clk);
        for (int it = 0; it < limit; it++) begin
            bus.sample_valid_i = (n == inj_at);
            if (n == inj_at) bus.sample_i = inj_val[DW-1:0];
            bus.coeff_we_i = (n == wr_at);
            if (n == wr_at) begin
                bus.coeff_addr_i = wr_addr;
                bus.coeff_data_i = wr_data[CW-1:0];
            end
            clk_en = !(n >= stall_at && n < stall_at + stall_len);
            rst    = (n == rst_at);
            @(posedge clk);
            n++;
            @(negedge clk);
            if (bus.result_valid_o && clk_en) begin
                nvalid++;
                if (lat < 0) begin
                    lat = n;
                    res = longint'(bus.result_o);
                end
            end
            if (!expect_none && lat >= 0) break;
        end
        bus.sample_valid_i = 1'b0;
        bus.coeff_we_i     = 1'b0;
        clk_en             = 1'b1;
        rst                = 1'b0;
        inj_at = -1; stall_at = -1; stall_len = 0; wr_at = -1; rst_at = -1;
        if (expect_none) chk("abort_no_pulse", nvalid, 0);
        else if (lat < 0) chk("result_timeout", nvalid, 1);
    endtask

    // ---------------- directed tests ----------------
    initial begin
        longint res;
        int     lat;
        longint imp_exp [5] = '{4, 1, 2, 1, 0};

        bus.sample_valid_i = 1'b0;
        bus.sample_i       = '0;
        bus.coeff_we_i     = 1'b0;
        bus.coeff_addr_i   = '0;
        bus.coeff_data_i   = '0;
`ifdef FIR_GAIN_EN
        bus.gain_i         = 8'h10;
`endif
        @(negedge clk);
        do_reset(2);
        chk("rst_ready", longint'(bus.ready_o), 1);
        chk("rst_busy", longint'(bus.busy_o), 0);
        chk("rst_result", longint'(bus.result_o), 0);
        chk("rst_valid", longint'(bus.result_valid_o), 0);

        // Basic MAC: coeffs 4,1,2,1 ; samples 5,2,3,4
        set_coeffs(4, 1, 2, 1);
        run_sample(5, 1'b0, res, lat); chk("basic1", res, 20);
        chk("basic_latency", lat, LAT);
        run_sample(2, 1'b0, res, lat); chk("basic2", res, 13);
        run_sample(3, 1'b0, res, lat); chk("basic3", res, 24);
        run_sample(4, 1'b0, res, lat); chk("basic4", res, 28);
        chk("basic4_latency", lat, LAT);

        // Impulse response from a cleared window
        do_reset(2);
        set_coeffs(4, 1, 2, 1);
        for (int i = 0; i < 5; i++) begin
            run_sample((i == 0) ? 1 : 0, 1'b0, res, lat);
            chk($sformatf("impulse%0d", i), res, imp_exp[i]);
        end

        // Saturation at both rails
        set_coeffs(32767, 32767, 32767, 32767);
        for (int i = 0; i < 4; i++) run_sample(32767, 1'b0, res, lat);
        chk("sat_pos", res, 32767);
        for (int i = 0; i < 4; i++) run_sample(-32768, 1'b0, res, lat);
        chk("sat_neg", res, -32768);

        // Sample offered while busy is dropped
        do_reset(2);
        set_coeffs(4, 1, 2, 1);
        inj_at = 1; inj_val = 100;
        run_sample(5, 1'b0, res, lat); chk("busy_ignore1", res, 20);
        run_sample(2, 1'b0, res, lat); chk("busy_ignore2", res, 13);

        // Clock enable low for 3 cycles mid-MAC
        stall_at = 2; stall_len = 3;
        run_sample(3, 1'b0, res, lat); chk("stall_value", res, 24);
        chk("stall_latency", lat, LAT + 3);

        // Write tap 2 in the cycle it is read: old value now, new value next sample
        wr_at = 2; wr_addr = 2'd2; wr_data = 10;
        run_sample(4, 1'b0, res, lat); chk("cwr_old", res, 28);
        run_sample(0, 1'b0, res, lat); chk("cwr_new", res, 36);

        // Reset mid-MAC: no pulse, window and coefficients cleared
        rst_at = 2;
        run_sample(7, 1'b1, res, lat);
        chk("abort_ready", longint'(bus.ready_o), 1);
        set_coeffs(4, 1, 2, 1);
        run_sample(0, 1'b0, res, lat); chk("abort_win_clear", res, 0);
        run_sample(1, 1'b0, res, lat); chk("abort_after", res, 4);

`ifdef FIR_GAIN_EN
        do_reset(2);
        set_coeffs(4, 1, 2, 1);
        bus.gain_i = 8'h20;
        run_sample(5, 1'b0, res, lat);
        run_sample(2, 1'b0, res, lat);
        run_sample(3, 1'b0, res, lat);
        run_sample(4, 1'b0, res, lat); chk("gain2x", res, 56);
        chk("gain_latency", lat, 6);
        do_reset(2);
        set_coeffs(4, 1, 2, 1);
        bus.gain_i = 8'h10;
        run_sample(5, 1'b0, res, lat);
        run_sample(2, 1'b0, res, lat);
        run_sample(3, 1'b0, res, lat);
        run_sample(4, 1'b0, res, lat); chk("gain1x", res, 28);
`endif

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL global_timeout: actual=%0d required=%0d", 1, 0);
        $fatal(1, "time limit");
    end

endmodule
